// File: rtl/blink_pulse_driver.sv
// Turns single-cycle event pulses into fixed-width blinks on a board pin.
// Events that arrive during a blink are queued and replayed with a fixed low gap.
module blink_pulse_driver #(
    parameter int unsigned ON_CYCLES  = 25_000_000,
    parameter int unsigned OFF_CYCLES = 12_500_000,
    parameter int unsigned PEND_W     = 4
) (
    input  logic              clk_hifreq,
    input  logic              rst,
    input  logic              pulse,
    input  logic              clear_ovf,
    output logic              pin,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned MaxCyc = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int unsigned TimerW = $clog2(MaxCyc + 1);

    localparam logic [TimerW-1:0] OnLast  = TimerW'(ON_CYCLES - 1);
    localparam logic [TimerW-1:0] OffLast = TimerW'(OFF_CYCLES - 1);
    localparam logic [PEND_W-1:0] PendMax = {PEND_W{1'b1}};

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StOn   = 2'b01,
        StGap  = 2'b10
    } state_e;

    state_e              state_q, state_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [PEND_W-1:0]   pending_q, pending_d;
    logic                overflow_q, overflow_d;
    logic                pin_q, pin_d;
    logic                consume;
    logic                dec;
    logic                drop;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        consume = 1'b0;
        dec     = 1'b0;
        unique case (state_q)
            StIdle: begin
                timer_d = '0;
                if (pulse) begin
                    state_d = StOn;
                    consume = 1'b1;
                end
            end
            StOn: begin
                if (timer_q == OnLast) begin
                    state_d = StGap;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            StGap: begin
                if (timer_q == OffLast) begin
                    timer_d = '0;
                    // Queued events take priority over a fresh pulse.
                    if (pending_q != '0) begin
                        state_d = StOn;
                        dec     = 1'b1;
                    end else if (pulse) begin
                        state_d = StOn;
                        consume = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    timer_d = timer_q + TimerW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        drop      = 1'b0;
        if (pulse && !consume) begin
            // A simultaneous dequeue frees a slot, so nothing is dropped then.
            if (!dec) begin
                if (pending_q == PendMax) begin
                    drop = 1'b1;
                end else begin
                    pending_d = pending_q + PEND_W'(1);
                end
            end
        end else if (dec) begin
            pending_d = pending_q - PEND_W'(1);
        end
        overflow_d = drop ? 1'b1 : (clear_ovf ? 1'b0 : overflow_q);
        pin_d      = (state_d == StOn);
    end

    always_ff @(posedge clk_hifreq or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            timer_q    <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
            pin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            pin_q      <= pin_d;
        end
    end

    assign pin      = pin_q;
    assign busy     = (state_q != StIdle);
    assign pending  = pending_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_blink_pulse_driver.sv
// Directed bench for blink_pulse_driver with ON=4, OFF=2, PEND_W=2.
// Each trace character k gives the input sampled at edge k and the outputs seen just after it.
module tb_blink_pulse_driver;

    logic       clk;
    logic       rst;
    logic       pulse;
    logic       clear_ovf;
    logic       pin;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int n_vec;
    int n_err;

    blink_pulse_driver #(
        .ON_CYCLES (4),
        .OFF_CYCLES(2),
        .PEND_W    (2)
    ) u_dut (
        .clk_hifreq(clk),
        .rst       (rst),
        .pulse     (pulse),
        .clear_ovf (clear_ovf),
        .pin       (pin),
        .busy      (busy),
        .pending   (pending),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int dig(input byte c);
        return int'(c) - 48;
    endfunction

    task automatic run_trace(input string tag, input string pul, input string clr,
                             input string pn, input string bs, input string pd,
                             input string ov);
        for (int k = 0; k < pul.len(); k++) begin
            pulse     = (pul[k] == "1");
            clear_ovf = (clr[k] == "1");
            step();
            check_eq($sformatf("%s[%0d].pin", tag, k), int'(pin), dig(pn[k]));
            check_eq($sformatf("%s[%0d].busy", tag, k), int'(busy), dig(bs[k]));
            check_eq($sformatf("%s[%0d].pending", tag, k), int'(pending), dig(pd[k]));
            check_eq($sformatf("%s[%0d].overflow", tag, k), int'(overflow), dig(ov[k]));
        end
        pulse     = 1'b0;
        clear_ovf = 1'b0;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        pulse     = 1'b0;
        clear_ovf = 1'b0;
        #23;
        check_eq("por.pin", int'(pin), 0);
        check_eq("por.busy", int'(busy), 0);
        check_eq("por.pending", int'(pending), 0);
        check_eq("por.overflow", int'(overflow), 0);
        rst = 1'b0;
        step();

        run_trace("single", "1000000", "0000000",
                  "1111000", "1111110", "0000000", "0000000");

        run_trace("three", "1110000000000000000", "0000000000000000000",
                  "1111001111001111000", "1111111111111111110",
                  "0122221111110000000", "0000000000000000000");

        run_trace("ovf", "1111110000000000000000000", "0000011000000000000000000",
                  "1111001111001111001111000", "1111111111111111111111110",
                  "0123332222221111110000000", "0000110000000000000000000");

        run_trace("gapfinal0", "1000001000000", "0000000000000",
                  "1111001111000", "1111111111110", "0000000000000", "0000000000000");

        run_trace("gapfinal1", "1100001000000000000", "0000000000000000000",
                  "1111001111001111000", "1111111111111111110",
                  "0111111111110000000", "0000000000000000000");

        // Async reset mid-blink with two events queued.
        run_trace("prerst", "111", "000", "111", "111", "012", "000");
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst.pin", int'(pin), 0);
        check_eq("rst.busy", int'(busy), 0);
        check_eq("rst.pending", int'(pending), 0);
        check_eq("rst.overflow", int'(overflow), 0);
        #4;
        rst = 1'b0;
        run_trace("postrst", "000", "000", "000", "000", "000", "000");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
